// File: rtl/alu_issue_stage.sv
// Execute stage around a combinational 64-bit ALU: one-entry X register, one-entry W result
// register, W->X forwarding and RV64 word-op operand shaping / result sign extension.
module alu_issue_stage #(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned RIDX_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,

  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [RIDX_W-1:0] dec_rs1_i,
  input  logic [RIDX_W-1:0] dec_rs2_i,
  input  logic [RIDX_W-1:0] dec_rd_i,
  input  logic [63:0]       dec_rv1_i,
  input  logic [63:0]       dec_rv2_i,
  input  logic [63:0]       dec_imm_i,
  input  logic [63:0]       dec_pc_i,
  input  logic              dec_use_pc_i,
  input  logic              dec_use_imm_i,
  input  logic              dec_word_i,
  input  logic [8:0]        dec_ctl_i,

  output logic [63:0]       alu_a_o,
  output logic [63:0]       alu_b_o,
  output logic [8:0]        alu_ctl_o,
  input  logic [63:0]       alu_out_i,

  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [RIDX_W-1:0] wb_rd_o,
  output logic [63:0]       wb_data_o
);

  // Control vector layout: {cflag,sum,and,xor,invB,lsh,rsh,ltu,lts}
  localparam int unsigned CtlCflag = 8;
  localparam int unsigned CtlLsh   = 3;
  localparam int unsigned CtlRsh   = 2;

  typedef struct packed {
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [RIDX_W-1:0] rd;
    logic [63:0]       rv1;
    logic [63:0]       rv2;
    logic [63:0]       imm;
    logic [63:0]       pc;
    logic              use_pc;
    logic              use_imm;
    logic              word;
    logic [8:0]        ctl;
  } xop_t;

  logic              x_valid_q, x_valid_d;
  xop_t              x_q, x_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RIDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [63:0]       wb_data_q, wb_data_d;

  logic        w_retire;
  logic        x_adv;
  logic        capture;
  logic        cap_fwd1, cap_fwd2;
  logic        x_fwd1, x_fwd2;
  logic [63:0] rv1, rv2;
  logic [63:0] op_a, op_b;
  logic [63:0] result;

  // Handshake and forwarding decisions
  always_comb begin
    w_retire    = wb_valid_q & wb_ready_i;
    x_adv       = x_valid_q & (~wb_valid_q | wb_ready_i);
    dec_ready_o = ~x_valid_q | x_adv;
    capture     = dec_valid_i & dec_ready_o & ~flush_i;

    // A result leaving W this edge would be lost to a newly captured op, so latch it directly.
    cap_fwd1 = FWD_EN & w_retire & (wb_rd_q != '0) & (wb_rd_q == dec_rs1_i);
    cap_fwd2 = FWD_EN & w_retire & (wb_rd_q != '0) & (wb_rd_q == dec_rs2_i);
    x_fwd1   = FWD_EN & wb_valid_q & (wb_rd_q != '0) & (wb_rd_q == x_q.rs1);
    x_fwd2   = FWD_EN & wb_valid_q & (wb_rd_q != '0) & (wb_rd_q == x_q.rs2);
  end

  // Operand selection and word-op shaping
  always_comb begin
    rv1 = x_fwd1 ? wb_data_q : x_q.rv1;
    rv2 = x_fwd2 ? wb_data_q : x_q.rv2;

    op_a = x_q.use_pc  ? x_q.pc  : rv1;
    op_b = x_q.use_imm ? x_q.imm : rv2;

    alu_a_o = op_a;
    alu_b_o = op_b;
    if (x_q.word && x_q.ctl[CtlRsh]) begin
      alu_a_o = {{32{x_q.ctl[CtlCflag] & op_a[31]}}, op_a[31:0]};
    end
    if (x_q.word && (x_q.ctl[CtlLsh] || x_q.ctl[CtlRsh])) begin
      alu_b_o = {59'b0, op_b[4:0]};
    end
    alu_ctl_o = x_q.ctl;

    result = x_q.word ? {{32{alu_out_i[31]}}, alu_out_i[31:0]} : alu_out_i;
  end

  // X register next state
  always_comb begin
    x_d       = x_q;
    x_valid_d = x_valid_q;
    if (flush_i) begin
      x_valid_d = 1'b0;
    end else if (capture) begin
      x_valid_d = 1'b1;
    end else if (x_adv) begin
      x_valid_d = 1'b0;
    end

    if (capture) begin
      x_d.rs1     = dec_rs1_i;
      x_d.rs2     = dec_rs2_i;
      x_d.rd      = dec_rd_i;
      x_d.rv1     = cap_fwd1 ? wb_data_q : dec_rv1_i;
      x_d.rv2     = cap_fwd2 ? wb_data_q : dec_rv2_i;
      x_d.imm     = dec_imm_i;
      x_d.pc      = dec_pc_i;
      x_d.use_pc  = dec_use_pc_i;
      x_d.use_imm = dec_use_imm_i;
      x_d.word    = dec_word_i;
      x_d.ctl     = dec_ctl_i;
    end
  end

  // W register next state; a flushed X op never lands here
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (x_adv && !flush_i) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = x_q.rd;
      wb_data_d  = result;
    end else if (w_retire) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_valid_q  <= 1'b0;
      x_q        <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      x_valid_q  <= x_valid_d;
      x_q        <= x_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural 64-bit ALU closing the loop.
module tb_alu_issue_stage;

  localparam logic [8:0] CSum   = 9'b0_1000_0000;
  localparam logic [8:0] CCflag = 9'b1_0000_0000;
  localparam logic [8:0] CRsh   = 9'b0_0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [63:0] dec_rv1, dec_rv2, dec_imm, dec_pc;
  logic        dec_use_pc, dec_use_imm, dec_word;
  logic [8:0]  dec_ctl;
  logic [63:0] alu_a, alu_b, alu_out;
  logic [8:0]  alu_ctl;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] ret_q[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.FWD_EN(1'b1), .RIDX_W(5)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .flush_i      (flush),
    .dec_valid_i  (dec_valid),
    .dec_ready_o  (dec_ready),
    .dec_rs1_i    (dec_rs1),
    .dec_rs2_i    (dec_rs2),
    .dec_rd_i     (dec_rd),
    .dec_rv1_i    (dec_rv1),
    .dec_rv2_i    (dec_rv2),
    .dec_imm_i    (dec_imm),
    .dec_pc_i     (dec_pc),
    .dec_use_pc_i (dec_use_pc),
    .dec_use_imm_i(dec_use_imm),
    .dec_word_i   (dec_word),
    .dec_ctl_i    (dec_ctl),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_ctl_o    (alu_ctl),
    .alu_out_i    (alu_out),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data)
  );

  // Reference ALU: {cflag,sum,and,xor,invB,lsh,rsh,ltu,lts}
  always_comb begin
    logic [63:0] bm;
    bm = alu_ctl[4] ? ~alu_b : alu_b;
    alu_out = '0;
    if (alu_ctl[7])      alu_out = alu_a + bm + {63'b0, alu_ctl[8]};
    else if (alu_ctl[6]) alu_out = alu_a & bm;
    else if (alu_ctl[5]) alu_out = alu_a ^ bm;
    else if (alu_ctl[3]) alu_out = alu_a << alu_b[5:0];
    else if (alu_ctl[2]) alu_out = alu_ctl[8] ? 64'($signed(alu_a) >>> alu_b[5:0])
                                              : alu_a >> alu_b[5:0];
    else if (alu_ctl[1]) alu_out = {63'b0, alu_a < bm};
    else if (alu_ctl[0]) alu_out = {63'b0, $signed(alu_a) < $signed(bm)};
  end

  // Retirement log: rd of every result accepted by writeback
  always @(posedge clk) begin
    if (!reset && wb_valid && wb_ready) ret_q.push_back(wb_rd);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [63:0] rv1, input logic [63:0] rv2,
                          input logic [63:0] imm, input logic [63:0] pc,
                          input logic use_pc, input logic use_imm, input logic word,
                          input logic [8:0] ctl);
    dec_valid   = 1'b1;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    dec_rd      = rd;
    dec_rv1     = rv1;
    dec_rv2     = rv2;
    dec_imm     = imm;
    dec_pc      = pc;
    dec_use_pc  = use_pc;
    dec_use_imm = use_imm;
    dec_word    = word;
    dec_ctl     = ctl;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_wb_valid got %0b expected 0", wb_valid);
    end
    vectors++;
    if (wb_rd !== 5'd0 || wb_data !== 64'd0) begin
      miscompares++; $display("FAIL reset_wb got rd=%0d data=%h expected 0/0", wb_rd, wb_data);
    end
    vectors++;
    if (dec_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_dec_ready got %0b expected 1", dec_ready);
    end
    vectors++;
    if (alu_ctl !== 9'd0 || alu_a !== 64'd0) begin
      miscompares++; $display("FAIL reset_alu got ctl=%h a=%h expected 0/0", alu_ctl, alu_a);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_bypass();
    wb_ready = 1'b1;
    ret_q.delete();
    // x5 = x1(7) + -3
    drive_op(5'd1, 5'd0, 5'd5, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b0, 1'b1, 1'b0,
             CSum);
    step();
    vectors++;
    if (alu_a !== 64'd7 || alu_b !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      miscompares++; $display("FAIL add_operands got a=%h b=%h expected 7/-3", alu_a, alu_b);
    end
    // x6 = x5 + x5 with stale regfile data
    drive_op(5'd5, 5'd5, 5'd6, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, CSum);
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'd4) begin
      miscompares++;
      $display("FAIL add_x5 got v=%0b rd=%0d data=%h expected 1/5/4", wb_valid, wb_rd, wb_data);
    end
    vectors++;
    if (alu_a !== 64'd4 || alu_b !== 64'd4) begin
      miscompares++; $display("FAIL x_bypass got a=%h b=%h expected 4/4", alu_a, alu_b);
    end
    idle();
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 64'd8) begin
      miscompares++;
      $display("FAIL add_x6 got v=%0b rd=%0d data=%h expected 1/6/8", wb_valid, wb_rd, wb_data);
    end
    step();
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++; $display("FAIL wb_drain got %0b expected 0", wb_valid);
    end

    // Capture-time bypass: x7 retires from W on the same edge x8's op is captured
    drive_op(5'd0, 5'd0, 5'd7, 64'd0, 64'd0, 64'd100, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    idle();
    step();
    drive_op(5'd7, 5'd0, 5'd8, 64'd0, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    vectors++;
    if (wb_valid !== 1'b0 || alu_a !== 64'd100) begin
      miscompares++;
      $display("FAIL cap_bypass got v=%0b a=%h expected 0/100", wb_valid, alu_a);
    end
    idle();
    step();
    vectors++;
    if (wb_rd !== 5'd8 || wb_data !== 64'd101) begin
      miscompares++; $display("FAIL cap_result got rd=%0d data=%h expected 8/101", wb_rd, wb_data);
    end

    // rd=0 must never forward
    drive_op(5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd55, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    drive_op(5'd0, 5'd0, 5'd9, 64'd3, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    vectors++;
    if (alu_a !== 64'd3) begin
      miscompares++; $display("FAIL rd0_no_fwd got a=%h expected 3", alu_a);
    end
    idle();
    step();
    vectors++;
    if (wb_rd !== 5'd9 || wb_data !== 64'd4) begin
      miscompares++; $display("FAIL rd0_result got rd=%0d data=%h expected 9/4", wb_rd, wb_data);
    end
    step();
  endtask

  task automatic test_word_ops();
    wb_ready = 1'b1;
    // ADDIW
    drive_op(5'd1, 5'd0, 5'd10, 64'h0000_0000_7FFF_FFFF, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b1,
             CSum);
    step();
    vectors++;
    if (alu_a !== 64'h0000_0000_7FFF_FFFF || alu_b !== 64'd1) begin
      miscompares++; $display("FAIL addiw_operands got a=%h b=%h", alu_a, alu_b);
    end
    // SRAW
    drive_op(5'd1, 5'd2, 5'd11, 64'h1234_5678_8000_0000, 64'h24, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1,
             CCflag | CRsh);
    step();
    vectors++;
    if (wb_rd !== 5'd10 || wb_data !== 64'hFFFF_FFFF_8000_0000) begin
      miscompares++;
      $display("FAIL addiw got rd=%0d data=%h expected 10/ffffffff80000000", wb_rd, wb_data);
    end
    vectors++;
    if (alu_a !== 64'hFFFF_FFFF_8000_0000 || alu_b !== 64'd4) begin
      miscompares++;
      $display("FAIL sraw_shape got a=%h b=%h expected ffffffff80000000/4", alu_a, alu_b);
    end
    // SRLW
    drive_op(5'd1, 5'd2, 5'd12, 64'h1234_5678_8000_0000, 64'h24, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1,
             CRsh);
    step();
    vectors++;
    if (wb_rd !== 5'd11 || wb_data !== 64'hFFFF_FFFF_F800_0000) begin
      miscompares++;
      $display("FAIL sraw got rd=%0d data=%h expected 11/fffffffff8000000", wb_rd, wb_data);
    end
    vectors++;
    if (alu_a !== 64'h0000_0000_8000_0000 || alu_b !== 64'd4) begin
      miscompares++;
      $display("FAIL srlw_shape got a=%h b=%h expected 80000000/4", alu_a, alu_b);
    end
    // AUIPC-style: A = pc
    drive_op(5'd0, 5'd0, 5'd13, 64'd0, 64'd0, 64'h20, 64'h1000, 1'b1, 1'b1, 1'b0, CSum);
    step();
    vectors++;
    if (wb_rd !== 5'd12 || wb_data !== 64'h0000_0000_0800_0000) begin
      miscompares++;
      $display("FAIL srlw got rd=%0d data=%h expected 12/8000000", wb_rd, wb_data);
    end
    vectors++;
    if (alu_a !== 64'h1000) begin
      miscompares++; $display("FAIL pc_select got a=%h expected 1000", alu_a);
    end
    // 64-bit SRA: no shaping, full 6-bit shift amount
    drive_op(5'd1, 5'd2, 5'd14, 64'h1234_5678_8000_0000, 64'h24, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0,
             CCflag | CRsh);
    step();
    vectors++;
    if (wb_data !== 64'h1020 || alu_b !== 64'h24) begin
      miscompares++; $display("FAIL auipc got data=%h b=%h expected 1020/24", wb_data, alu_b);
    end
    idle();
    step();
    vectors++;
    if (wb_rd !== 5'd14 || wb_data !== 64'h0000_0000_0123_4567) begin
      miscompares++;
      $display("FAIL sra64 got rd=%0d data=%h expected 14/1234567", wb_rd, wb_data);
    end
    step();
  endtask

  task automatic test_stall();
    ret_q.delete();
    wb_ready = 1'b0;
    drive_op(5'd0, 5'd0, 5'd10, 64'd0, 64'd0, 64'd11, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    drive_op(5'd0, 5'd0, 5'd11, 64'd0, 64'd0, 64'd22, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    drive_op(5'd0, 5'd0, 5'd12, 64'd0, 64'd0, 64'd33, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (dec_ready !== 1'b0 || wb_rd !== 5'd10 || wb_data !== 64'd11) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got ready=%0b rd=%0d data=%h expected 0/10/11",
                 i, dec_ready, wb_rd, wb_data);
      end
      step();
    end
    wb_ready = 1'b1;
    step();
    idle();
    vectors++;
    if (wb_rd !== 5'd11 || wb_data !== 64'd22) begin
      miscompares++; $display("FAIL stall_release got rd=%0d data=%h expected 11/22", wb_rd, wb_data);
    end
    step();
    step();
    vectors++;
    if (ret_q.size() != 3 || ret_q[0] !== 5'd10 || ret_q[1] !== 5'd11 || ret_q[2] !== 5'd12) begin
      miscompares++; $display("FAIL stall_order got %p expected '{10,11,12}", ret_q);
    end
  endtask

  task automatic test_flush();
    ret_q.delete();
    wb_ready = 1'b1;
    drive_op(5'd0, 5'd0, 5'd13, 64'd0, 64'd0, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    drive_op(5'd0, 5'd0, 5'd15, 64'd0, 64'd0, 64'd6, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    // W=x13 retiring, X=x15 killed, decode x16 dropped
    drive_op(5'd0, 5'd0, 5'd16, 64'd0, 64'd0, 64'd7, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    vectors++;
    if (wb_valid !== 1'b0 || dec_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_state got v=%0b ready=%0b expected 0/1", wb_valid, dec_ready);
    end
    step();
    step();
    vectors++;
    if (ret_q.size() != 1 || ret_q[0] !== 5'd13) begin
      miscompares++; $display("FAIL flush_retire got %p expected '{13}", ret_q);
    end

    // Flush while W is stalled: W keeps its result
    ret_q.delete();
    wb_ready = 1'b0;
    drive_op(5'd0, 5'd0, 5'd17, 64'd0, 64'd0, 64'd8, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    drive_op(5'd0, 5'd0, 5'd18, 64'd0, 64'd0, 64'd9, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd17 || wb_data !== 64'd8) begin
      miscompares++;
      $display("FAIL flush_stalled_w got v=%0b rd=%0d data=%h expected 1/17/8",
               wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1;
    step();
    step();
    vectors++;
    if (ret_q.size() != 1 || ret_q[0] !== 5'd17) begin
      miscompares++; $display("FAIL flush_stalled_retire got %p expected '{17}", ret_q);
    end
  endtask

  task automatic test_reset_mid();
    ret_q.delete();
    wb_ready = 1'b0;
    drive_op(5'd0, 5'd0, 5'd20, 64'd0, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    drive_op(5'd0, 5'd0, 5'd21, 64'd0, 64'd0, 64'd2, 64'd0, 1'b0, 1'b1, 1'b0, CSum);
    step();
    idle();
    reset = 1'b1;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || dec_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid got v=%0b ready=%0b expected 0/1", wb_valid, dec_ready);
    end
    vectors++;
    if (wb_rd !== 5'd0 || wb_data !== 64'd0 || alu_ctl !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_mid_fields got rd=%0d data=%h ctl=%h expected 0", wb_rd, wb_data, alu_ctl);
    end
    @(negedge clk);
    reset = 1'b0;
    wb_ready = 1'b1;
    step();
    step();
    vectors++;
    if (wb_valid !== 1'b0 || ret_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_stale got v=%0b retired=%0d expected 0/0", wb_valid, ret_q.size());
    end
  endtask

  initial begin
    flush = 1'b0;
    wb_ready = 1'b1;
    idle();
    drive_op(5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 9'd0);
    idle();
    test_reset();
    test_bypass();
    test_word_ops();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
